turbine_frame_packer: RTL and testbench

//  Downstream of the turbine measurement stage: consumes per-channel 16-bit word strobes (4 words per sample).

---
 rtl/turbine_pkg.sv | 31 +++
 rtl/turbine_frame_packer_if.sv | 24 ++
 rtl/turbine_ch_capture.sv | 64 ++++++
 rtl/turbine_frame_packer.sv | 159 +++++++++++++++
 tb/tb_turbine_frame_packer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/turbine_pkg.sv
// Shared constants, types and helpers for the turbine frame packer.
// Frame layout: header, four data words, checksum.
package turbine_pkg;

  localparam int FRAME_LEN  = 6;
  localparam int DATA_WORDS = 4;
  localparam int WORD_W     = 16;
  localparam int CH_W       = 4;
  localparam int BEAT_W     = 3;

  localparam logic [7:0] HDR_TAG_DEF = 8'h5A;

  localparam logic [BEAT_W-1:0] BEAT_HDR  = 3'd0;
  localparam logic [BEAT_W-1:0] BEAT_W0   = 3'd1;
  localparam logic [BEAT_W-1:0] BEAT_W3   = 3'd4;
  localparam logic [BEAT_W-1:0] BEAT_CSUM = 3'd5;

  typedef enum logic {
    IDLE,
    SEND
  } fsm_e;

  function automatic logic [CH_W-1:0] ch_wrap_inc(
    input logic [CH_W-1:0] ch,
    input int              n
  );
    if (int'(ch) + 1 >= n) return '0;
    return ch + 1'b1;
  endfunction

endpackage

// File: rtl/turbine_frame_packer_if.sv
// AXI-Stream style 16-bit frame stream.
// Ports: tvalid/tdata/tlast from master, tready from slave.
interface turbine_frame_packer_if;

  logic        tvalid;
  logic        tready;
  logic [15:0] tdata;
  logic        tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/turbine_ch_capture.sv
// One channel: gathers four word strobes into a record.
// Ports: wr strobe/data in, rel/ovf_clr in, full/ovf/buf out.
module turbine_ch_capture
  import turbine_pkg::*;
(
  input  logic                         sys_clk_i,
  input  logic                         rst_n_i,
  input  logic                         wr_en_i,
  input  logic [WORD_W-1:0]            wr_din_i,
  input  logic                         rel_i,
  input  logic                         ovf_clr_i,
  output logic                         full_o,
  output logic                         ovf_o,
  output logic [DATA_WORDS*WORD_W-1:0] buf_o
);

  logic [1:0]        idx_q;
  logic              full_q;
  logic              ovf_q;
  logic [WORD_W-1:0] buf_q [DATA_WORDS];

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      for (int i = 0; i < DATA_WORDS; i++)
        buf_q[i] <= '0;
    end else if (rel_i) begin
      // Release frees the slot first, so a
      // same-cycle strobe starts a new record.
      full_q <= 1'b0;
      if (wr_en_i) begin
        buf_q[0] <= wr_din_i;
        idx_q    <= 2'd1;
      end else begin
        idx_q    <= 2'd0;
      end
    end else if (wr_en_i && !full_q) begin
      buf_q[idx_q] <= wr_din_i;
      idx_q        <= idx_q + 2'd1;
      if (idx_q == 2'd3)
        full_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      ovf_q <= 1'b0;
    else if (wr_en_i && full_q && !rel_i)
      ovf_q <= 1'b1;
    else if (ovf_clr_i)
      ovf_q <= 1'b0;
  end

  always_comb begin
    buf_o = '0;
    for (int i = 0; i < DATA_WORDS; i++)
      buf_o[i*WORD_W +: WORD_W] = buf_q[i];
  end

  assign full_o = full_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/turbine_frame_packer.sv
// Round-robins full channel records into one 16-bit frame stream.
// Ports: clk/rst, per-ch strobes, m_axis master, ovf clr/flags, frame count.
module turbine_frame_packer
  import turbine_pkg::*;
#(
  parameter int         TURBINE_NUM = 10,
  parameter logic [7:0] HDR_TAG     = HDR_TAG_DEF
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_n_i,
  input  logic [TURBINE_NUM-1:0]        wr_en_i,
  input  logic [TURBINE_NUM*WORD_W-1:0] wr_din_i,
  turbine_frame_packer_if.master        m_axis,
  input  logic                          ovf_clr_i,
  output logic [TURBINE_NUM-1:0]        ovf_o,
  output logic [31:0]                   frame_cnt_o
);

  logic [TURBINE_NUM-1:0]        full_w;
  logic [TURBINE_NUM-1:0]        rel_w;
  logic [DATA_WORDS*WORD_W-1:0]  cap_buf [TURBINE_NUM];

  fsm_e              state_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   rr_q;
  logic [BEAT_W-1:0] beat_q;
  logic              tvalid_q;
  logic              tlast_q;
  logic [WORD_W-1:0] tdata_q;
  logic [WORD_W-1:0] csum_q;
  logic [31:0]       frame_cnt_q;

  logic              sel_vld_d;
  logic              sel_vld_q;
  logic [CH_W-1:0]   sel_ch_d;
  logic [CH_W-1:0]   sel_ch_q;

  logic              fire;
  logic              done;
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] hdr_word;

  for (genvar g = 0; g < TURBINE_NUM; g++) begin : g_cap
    turbine_ch_capture u_cap (
      .sys_clk_i (sys_clk_i),
      .rst_n_i   (rst_n_i),
      .wr_en_i   (wr_en_i[g]),
      .wr_din_i  (wr_din_i[g*WORD_W +: WORD_W]),
      .rel_i     (rel_w[g]),
      .ovf_clr_i (ovf_clr_i),
      .full_o    (full_w[g]),
      .ovf_o     (ovf_o[g]),
      .buf_o     (cap_buf[g])
    );
  end

  assign fire = tvalid_q & m_axis.tready;
  assign done = (state_q == SEND) && fire
             && (beat_q == BEAT_CSUM);

  always_comb begin
    rel_w = '0;
    for (int i = 0; i < TURBINE_NUM; i++)
      rel_w[i] = done && (ch_q == CH_W'(i));
  end

  // Selection is registered; on the release edge it
  // already skips the freed channel and uses the new
  // pointer, so back-to-back frames lose one cycle.
  always_comb begin
    logic [TURBINE_NUM-1:0] mask;
    logic [CH_W-1:0]        ptr;
    int                     idx;
    mask      = full_w & ~rel_w;
    ptr       = done ? ch_wrap_inc(ch_q, TURBINE_NUM)
                     : rr_q;
    sel_vld_d = 1'b0;
    sel_ch_d  = '0;
    idx       = 0;
    for (int k = 0; k < TURBINE_NUM; k++) begin
      idx = int'(ptr) + k;
      if (idx >= TURBINE_NUM)
        idx = idx - TURBINE_NUM;
      if (!sel_vld_d && mask[idx]) begin
        sel_vld_d = 1'b1;
        sel_ch_d  = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_vld_q <= 1'b0;
      sel_ch_q  <= '0;
    end else begin
      sel_vld_q <= sel_vld_d;
      sel_ch_q  <= sel_ch_d;
    end
  end

  assign cur_word = cap_buf[ch_q][{beat_q[1:0], 4'b0} +: WORD_W];
  assign hdr_word = {HDR_TAG, 4'h0, sel_ch_q};

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      rr_q        <= '0;
      beat_q      <= BEAT_HDR;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      csum_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_vld_q) begin
            state_q  <= SEND;
            ch_q     <= sel_ch_q;
            beat_q   <= BEAT_HDR;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= hdr_word;
            csum_q   <= hdr_word;
          end
        end
        SEND: begin
          if (fire) begin
            if (beat_q == BEAT_CSUM) begin
              state_q     <= IDLE;
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
              rr_q        <= ch_wrap_inc(ch_q, TURBINE_NUM);
              frame_cnt_q <= frame_cnt_q + 32'd1;
            end else begin
              beat_q <= beat_q + 3'd1;
              // beat_q 0..3 is followed by data word beat_q
              if (beat_q == BEAT_W3) begin
                tdata_q <= csum_q;
                tlast_q <= 1'b1;
              end else begin
                tdata_q <= cur_word;
                csum_q  <= csum_q + cur_word;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_turbine_frame_packer.sv
// Scoreboard bench for turbine_frame_packer.
// Expected frames queued at stimulus, popped on accepted beats.
module tb_turbine_frame_packer;
  import turbine_pkg::*;

  localparam int N = 10;

  logic            sys_clk_i = 1'b0;
  logic            rst_n_i   = 1'b0;
  logic [N-1:0]    wr_en_i   = '0;
  logic [N*16-1:0] wr_din_i  = '0;
  logic            ovf_clr_i = 1'b0;
  logic [N-1:0]    ovf_o;
  logic [31:0]     frame_cnt_o;

  turbine_frame_packer_if m_axis ();

  turbine_frame_packer #(
    .TURBINE_NUM (N),
    .HDR_TAG     (8'h5A)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .rst_n_i     (rst_n_i),
    .wr_en_i     (wr_en_i),
    .wr_din_i    (wr_din_i),
    .m_axis      (m_axis),
    .ovf_clr_i   (ovf_clr_i),
    .ovf_o       (ovf_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int          total = 0;
  int          bad   = 0;
  int          beats_acc = 0;
  logic [16:0] exp_q [$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk_i) begin
    logic [16:0] e;
    if (!rst_n_i) begin
      beats_acc = 0;
    end else if (m_axis.tvalid && m_axis.tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat",
              {15'd0, m_axis.tlast, m_axis.tdata},
              32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat",
              {15'd0, m_axis.tlast, m_axis.tdata},
              {15'd0, e});
      end
      beats_acc = (beats_acc == 5) ? 0 : beats_acc + 1;
    end
  end

  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic push_frame(int ch, logic [15:0] w [4]);
    logic [15:0] hdr;
    logic [15:0] s;
    hdr = {8'h5A, 4'h0, 4'(ch)};
    s   = hdr;
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, w[i]});
      s = s + w[i];
    end
    exp_q.push_back({1'b1, s});
  endtask

  task automatic put(int ch, logic [15:0] w);
    wr_en_i[ch] = 1'b1;
    wr_din_i[ch*16 +: 16] = w;
  endtask

  task automatic sample(int ch, logic [15:0] w [4]);
    for (int i = 0; i < 4; i++) begin
      put(ch, w[i]);
      tick();
      wr_en_i = '0;
    end
  endtask

  task automatic sample2(int a, logic [15:0] wa [4],
                         int b, logic [15:0] wb [4]);
    for (int i = 0; i < 4; i++) begin
      put(a, wa[i]);
      put(b, wb[i]);
      tick();
      wr_en_i = '0;
    end
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !m_axis.tvalid) break;
      tick();
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_beat(string tag, int n);
    for (int i = 0; i < 100; i++) begin
      if (m_axis.tvalid && beats_acc == n) break;
      tick();
    end
    check(tag, {m_axis.tvalid, 31'(beats_acc)},
          {1'b1, 31'(n)});
  endtask

  task automatic wait_last(string tag);
    for (int i = 0; i < 100; i++) begin
      if (m_axis.tvalid && m_axis.tlast) break;
      tick();
    end
    check(tag, {31'd0, m_axis.tvalid && m_axis.tlast}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wa [4];
    logic [15:0] wb [4];

    m_axis.tready = 1'b1;
    #2;
    check("rst_tvalid", 32'(m_axis.tvalid), 0);
    check("rst_tdata",  32'(m_axis.tdata),  0);
    check("rst_tlast",  32'(m_axis.tlast),  0);
    check("rst_ovf",    32'(ovf_o),         0);
    check("rst_cnt",    frame_cnt_o,        0);
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();

    // basic frame plus latency
    wa = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    push_frame(0, wa);
    for (int i = 0; i < 4; i++) begin
      put(0, wa[i]);
      tick();
      wr_en_i = '0;
    end
    check("lat_e0", 32'(m_axis.tvalid), 0);
    tick();
    check("lat_e1", 32'(m_axis.tvalid), 0);
    tick();
    check("lat_e2", 32'(m_axis.tvalid), 1);
    check("lat_hdr", 32'(m_axis.tdata), 32'h5A00);
    drain("drain_t1");
    check("cnt_t1", frame_cnt_o, 1);

    // stall on beat 2
    push_frame(0, wa);
    sample(0, wa);
    wait_beat("wait_b2", 2);
    m_axis.tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_data",  32'(m_axis.tdata),  32'h0002);
      check("stall_valid", 32'(m_axis.tvalid), 1);
    end
    check("stall_beats", beats_acc, 2);
    m_axis.tready = 1'b1;
    drain("drain_t3");
    check("cnt_t3", frame_cnt_o, 2);

    // ch3 and ch7 together, rr at 1
    wa = '{16'h3001, 16'h3002, 16'h3003, 16'h3004};
    wb = '{16'h7001, 16'h7002, 16'h7003, 16'h7004};
    push_frame(3, wa);
    push_frame(7, wb);
    sample2(3, wa, 7, wb);
    drain("drain_t2");
    check("cnt_t2", frame_cnt_o, 4);

    // rr now 8: ch9 ahead of ch2
    wa = '{16'h2001, 16'h2002, 16'h2003, 16'h2004};
    wb = '{16'h9001, 16'h9002, 16'h9003, 16'h9004};
    push_frame(9, wb);
    push_frame(2, wa);
    sample2(2, wa, 9, wb);
    drain("drain_rr");
    check("cnt_rr", frame_cnt_o, 6);

    // overflow while stalled
    m_axis.tready = 1'b0;
    wa = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    push_frame(1, wa);
    sample(1, wa);
    check("ovf_pre", 32'(ovf_o), 0);
    put(1, 16'hBEEF);
    tick();
    wr_en_i = '0;
    check("ovf_set", 32'(ovf_o), 32'h002);
    repeat (3) tick();
    m_axis.tready = 1'b1;
    drain("drain_t4");
    check("ovf_sticky", 32'(ovf_o), 32'h002);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("ovf_clr", 32'(ovf_o), 0);
    check("cnt_t4", frame_cnt_o, 7);

    // strobe coinciding with release
    wa = '{16'h5001, 16'h5002, 16'h5003, 16'h5004};
    push_frame(2, wa);
    sample(2, wa);
    wait_last("wait_last");
    put(2, 16'hA5A5);
    tick();
    wr_en_i = '0;
    check("rel_ovf", 32'(ovf_o), 0);
    wb = '{16'hA5A5, 16'h5102, 16'h5103, 16'h5104};
    push_frame(2, wb);
    for (int i = 1; i < 4; i++) begin
      put(2, wb[i]);
      tick();
      wr_en_i = '0;
    end
    drain("drain_t5");
    check("cnt_t5", frame_cnt_o, 9);

    // reset during beat 3, ch5 partial capture
    wa = '{16'h6001, 16'h6002, 16'h6003, 16'h6004};
    push_frame(4, wa);
    sample(4, wa);
    put(5, 16'hC001);
    tick();
    put(5, 16'hC002);
    tick();
    wr_en_i = '0;
    wait_beat("wait_b3", 3);
    rst_n_i = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_axis.tvalid), 0);
    check("arst_cnt",    frame_cnt_o,        0);
    exp_q.delete();
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();
    check("post_ovf",    32'(ovf_o),         0);
    check("post_tvalid", 32'(m_axis.tvalid), 0);
    wb = '{16'h7701, 16'h7702, 16'h7703, 16'h7704};
    push_frame(5, wb);
    sample(5, wb);
    drain("drain_t6");
    check("cnt_t6", frame_cnt_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
